// File: rtl/axil_multi_adder_pkg.sv
// Shared constants and types for the AXI4-Lite multi-operand adder.
// Register offsets are word indices; byte address = index * (DATA_WIDTH/8).
package axil_multi_adder_pkg;

  localparam int unsigned RegCtrl   = 0;
  localparam int unsigned RegStatus = 1;
  localparam int unsigned RegResult = 2;
  localparam int unsigned RegRsvd   = 3;
  localparam int unsigned RegOpBase = 4;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned CtrlStart  = 0;
  localparam int unsigned CtrlMode   = 1;
  localparam int unsigned CtrlSigned = 2;

  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatDone = 1;
  localparam int unsigned StatOvf  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StAcc
  } state_e;

endpackage

// File: rtl/axil_multi_adder_core.sv
// Sequential accumulate engine: loads OP[0], then adds or subtracts one operand
// per cycle, tracking sticky unsigned carry/borrow or signed overflow.
module axil_multi_adder_core
  import axil_multi_adder_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumOperands = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             sub_i,
  input  logic                             signed_i,
  input  logic [NumOperands*DataWidth-1:0] operands_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             ovf_o,
  output logic [DataWidth-1:0]             result_o
);

  localparam int unsigned IdxW = $clog2(NumOperands);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumOperands - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic [DataWidth-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [DataWidth-1:0] ops [NumOperands];
  logic [DataWidth-1:0] op_sel;
  logic [DataWidth:0]   step;
  logic                 step_ovf;
  logic                 a_msb, b_msb, r_msb;
  logic                 last_step;

  always_comb begin
    for (int unsigned i = 0; i < NumOperands; i++) begin
      ops[i] = operands_i[i*DataWidth +: DataWidth];
    end
  end

  assign op_sel    = ops[idx_q];
  assign last_step = (idx_q == LastIdx);

  // The extra top bit of step is the carry on add and the borrow on subtract.
  always_comb begin
    if (sub_i) begin
      step = {1'b0, acc_q} - {1'b0, op_sel};
    end else begin
      step = {1'b0, acc_q} + {1'b0, op_sel};
    end
    a_msb = acc_q[DataWidth-1];
    b_msb = op_sel[DataWidth-1];
    r_msb = step[DataWidth-1];
    if (signed_i) begin
      step_ovf = sub_i ? ((a_msb != b_msb) && (r_msb != a_msb))
                       : ((a_msb == b_msb) && (r_msb != a_msb));
    end else begin
      step_ovf = step[DataWidth];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  state_d = StAcc;
      StAcc:   if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    unique case (state_q)
      StLoad: begin
        acc_d  = ops[0];
        idx_d  = IdxW'(1);
        ovf_d  = 1'b0;
        done_d = 1'b0;
      end
      StAcc: begin
        acc_d = step[DataWidth-1:0];
        ovf_d = ovf_q | step_ovf;
        idx_d = idx_q + IdxW'(1);
        if (last_step) begin
          result_d = step[DataWidth-1:0];
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != StIdle);
    done_o   = done_q;
    ovf_o    = ovf_q;
    result_o = result_q;
  end

endmodule

// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave exposing CTRL/STATUS/RESULT and NUM_OPERANDS operand registers
// in front of the sequential accumulate core.
module axil_multi_adder
  import axil_multi_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned NUM_OPERANDS = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Lsb   = $clog2(StrbW);

  logic                  awready_q, awready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  mode_q, mode_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] op_q [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] op_d [NUM_OPERANDS];

  logic                               wr_en, rd_en, start;
  logic                               wr_aligned, rd_aligned;
  logic [31:0]                        wr_word, rd_word;
  logic                               wr_is_ctrl, wr_is_op, wr_is_rsvd;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic [1:0]                         rd_resp;
  logic [NUM_OPERANDS*DATA_WIDTH-1:0] operands;
  logic                               busy, core_done, core_ovf;
  logic [DATA_WIDTH-1:0]              core_result;

  assign wr_en      = awready_q && s1_axi_awvalid && s1_axi_wvalid;
  assign rd_en      = arready_q && s1_axi_arvalid;
  assign wr_aligned = (s1_axi_awaddr[Lsb-1:0] == '0);
  assign rd_aligned = (s1_axi_araddr[Lsb-1:0] == '0);
  assign wr_word    = 32'(s1_axi_awaddr >> Lsb);
  assign rd_word    = 32'(s1_axi_araddr >> Lsb);
  assign wr_is_ctrl = wr_aligned && (wr_word == RegCtrl);
  assign wr_is_rsvd = wr_aligned && (wr_word == RegRsvd);
  assign wr_is_op   = wr_aligned && (wr_word >= RegOpBase) &&
                      (wr_word < RegOpBase + NUM_OPERANDS);

  always_comb begin
    for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
      operands[i*DATA_WIDTH +: DATA_WIDTH] = op_q[i];
    end
  end

  // Write channel: AW and W are only ever accepted together, one per response.
  always_comb begin
    awready_d = s1_axi_awvalid && s1_axi_wvalid && !bvalid_q && !awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mode_d    = mode_q;
    signed_d  = signed_q;
    op_d      = op_q;
    start     = 1'b0;
    if (bvalid_q && s1_axi_bready) begin
      bvalid_d = 1'b0;
    end
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = RespOkay;
      if ((wr_is_ctrl || wr_is_op) && busy) begin
        bresp_d = RespSlverr;
      end else if (wr_is_ctrl) begin
        if (s1_axi_wstrb[0]) begin
          mode_d   = s1_axi_wdata[CtrlMode];
          signed_d = s1_axi_wdata[CtrlSigned];
          start    = s1_axi_wdata[CtrlStart];
        end
      end else if (wr_is_op) begin
        for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
          if (wr_word == RegOpBase + i) begin
            for (int unsigned b = 0; b < StrbW; b++) begin
              if (s1_axi_wstrb[b]) begin
                op_d[i][8*b +: 8] = s1_axi_wdata[8*b +: 8];
              end
            end
          end
        end
      end else if (!wr_is_rsvd) begin
        bresp_d = RespSlverr;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespSlverr;
    if (rd_aligned) begin
      if (rd_word == RegCtrl) begin
        rd_data[CtrlMode]   = mode_q;
        rd_data[CtrlSigned] = signed_q;
        rd_resp             = RespOkay;
      end else if (rd_word == RegStatus) begin
        rd_data[StatBusy] = busy;
        rd_data[StatDone] = core_done;
        rd_data[StatOvf]  = core_ovf;
        rd_resp           = RespOkay;
      end else if (rd_word == RegResult) begin
        rd_data = core_result;
        rd_resp = RespOkay;
      end else if (rd_word == RegRsvd) begin
        rd_resp = RespOkay;
      end else begin
        for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
          if (rd_word == RegOpBase + i) begin
            rd_data = op_q[i];
            rd_resp = RespOkay;
          end
        end
      end
    end
  end

  // Read data is captured from current register state at the acceptance edge.
  always_comb begin
    arready_d = s1_axi_arvalid && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (rvalid_q && s1_axi_rready) begin
      rvalid_d = 1'b0;
    end
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      mode_q    <= 1'b0;
      signed_q  <= 1'b0;
      op_q      <= '{default: '0};
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      mode_q    <= mode_d;
      signed_q  <= signed_d;
      op_q      <= op_d;
    end
  end

  assign s1_axi_awready = awready_q;
  assign s1_axi_wready  = awready_q;
  assign s1_axi_bvalid  = bvalid_q;
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = arready_q;
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

  axil_multi_adder_core #(
    .DataWidth  (DATA_WIDTH),
    .NumOperands(NUM_OPERANDS)
  ) u_core (
    .clk_i     (s1_axi_aclk),
    .rst_i     (s1_axi_areset),
    .start_i   (start),
    .sub_i     (mode_q),
    .signed_i  (signed_q),
    .operands_i(operands),
    .busy_o    (busy),
    .done_o    (core_done),
    .ovf_o     (core_ovf),
    .result_o  (core_result)
  );

endmodule

// File: tb/tb_axil_multi_adder.sv
// Directed bench for axil_multi_adder: register access table, run table with
// hand-computed sums, START-to-DONE timing sweep, and handshake corner cases.
module tb_axil_multi_adder;

  localparam int N = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_multi_adder #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (8),
    .NUM_OPERANDS(N)
  ) dut (
    .s1_axi_aclk   (clk),
    .s1_axi_areset (rst),
    .s1_axi_awaddr (awaddr),
    .s1_axi_awvalid(awvalid),
    .s1_axi_awready(awready),
    .s1_axi_wdata  (wdata),
    .s1_axi_wstrb  (wstrb),
    .s1_axi_wvalid (wvalid),
    .s1_axi_wready (wready),
    .s1_axi_bresp  (bresp),
    .s1_axi_bvalid (bvalid),
    .s1_axi_bready (bready),
    .s1_axi_araddr (araddr),
    .s1_axi_arvalid(arvalid),
    .s1_axi_arready(arready),
    .s1_axi_rdata  (rdata),
    .s1_axi_rresp  (rresp),
    .s1_axi_rvalid (rvalid),
    .s1_axi_rready (rready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic timed_out(input string name);
    n_total++;
    $display("FAIL %s: handshake timed out, got no response required one", name);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int acc);
    bit ok = 0;
    resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    acc = cyc; awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) begin timed_out("aw_accept"); return; end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    if (!ok) begin timed_out("b_valid"); return; end
    resp = bresp; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, input int dly,
                          output logic [31:0] d, output logic [1:0] resp, output int acc);
    bit ok = 0;
    d = 32'hDEAD_BEEF; resp = 2'b11;
    for (int i = 0; i < dly; i++) begin @(posedge clk); #1; end
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    acc = cyc; arvalid = 1'b0;
    if (!ok) begin timed_out("ar_accept"); return; end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    if (!ok) begin timed_out("r_valid"); return; end
    d = rdata; resp = rresp; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } reg_vec_t;

  typedef struct {
    logic [31:0] o0, o1, o2, o3;
    logic [2:0]  ctrl;
    logic [31:0] result;
    logic [2:0]  status;
  } run_vec_t;

  reg_vec_t    rv [13];
  run_vec_t    runs [9];
  logic [1:0]  resp;
  logic [31:0] data;
  int          t_acc, e_acc, dummy;
  logic [31:0] held;
  bit          ok;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0; wdata = '0; wstrb = '0;

    rv[0]  = '{8'h10, 32'h1122_3344, 4'hF, OKAY,   8'h10, 32'h1122_3344, OKAY};
    rv[1]  = '{8'h14, 32'hAABB_CCDD, 4'h1, OKAY,   8'h14, 32'h0000_00DD, OKAY};
    rv[2]  = '{8'h18, 32'hCAFE_BABE, 4'hC, OKAY,   8'h18, 32'hCAFE_0000, OKAY};
    rv[3]  = '{8'h04, 32'hFFFF_FFFF, 4'hF, SLVERR, 8'h04, 32'h0,         OKAY};
    rv[4]  = '{8'h08, 32'hFFFF_FFFF, 4'hF, SLVERR, 8'h08, 32'h0,         OKAY};
    rv[5]  = '{8'h0C, 32'hFFFF_FFFF, 4'hF, OKAY,   8'h0C, 32'h0,         OKAY};
    rv[6]  = '{8'h11, 32'hFFFF_FFFF, 4'hF, SLVERR, 8'h10, 32'h1122_3344, OKAY};
    rv[7]  = '{8'hFC, 32'h1234_5678, 4'hF, SLVERR, 8'hFC, 32'h0,         SLVERR};
    rv[8]  = '{8'h20, 32'h1234_5678, 4'hF, SLVERR, 8'h20, 32'h0,         SLVERR};
    rv[9]  = '{8'h00, 32'h0000_0006, 4'h1, OKAY,   8'h00, 32'h6,         OKAY};
    rv[10] = '{8'h00, 32'h0000_0000, 4'hE, OKAY,   8'h00, 32'h6,         OKAY};
    rv[11] = '{8'h00, 32'h0000_0000, 4'h1, OKAY,   8'h00, 32'h0,         OKAY};
    rv[12] = '{8'h1C, 32'h0000_0005, 4'hF, OKAY,   8'h1C, 32'h5,         OKAY};

    runs[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 3'b001, 32'd10, 3'b010};
    runs[1] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3'b001, 32'h0, 3'b110};
    runs[2] = '{32'd1, 32'd2, 32'd3, 32'd4, 3'b001, 32'd10, 3'b010};
    runs[3] = '{32'd0, 32'd1, 32'd0, 32'd0, 3'b011, 32'hFFFF_FFFF, 3'b110};
    runs[4] = '{32'h8000_0000, 32'd1, 32'd0, 32'd0, 3'b111, 32'h7FFF_FFFF, 3'b110};
    runs[5] = '{32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 3'b101, 32'h7FFF_FFFF, 3'b110};
    runs[6] = '{32'd10, 32'd3, 32'd2, 32'd1, 3'b011, 32'd4, 3'b010};
    runs[7] = '{32'd5, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 3'b101, 32'd5, 3'b010};
    runs[8] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 3'b001, 32'h0, 3'b110};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_ready", {awready, wready, arready}, 3'b000);
    check("reset_rdata", {rdata, rresp, bresp}, '0);
    axi_read(8'h04, 0, data, resp, dummy);
    check("reset_status", {data, resp}, {32'h0, OKAY});
    axi_read(8'h08, 0, data, resp, dummy);
    check("reset_result", {data, resp}, {32'h0, OKAY});

    // Reset in the middle of a run aborts it.
    axi_write(8'h10, 32'd7, 4'hF, resp, dummy);
    axi_write(8'h14, 32'd8, 4'hF, resp, dummy);
    axi_write(8'h00, 32'h1, 4'h1, resp, dummy);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    axi_read(8'h04, 0, data, resp, dummy);
    check("midrun_reset_status", data, 32'h0);
    axi_read(8'h08, 0, data, resp, dummy);
    check("midrun_reset_result", data, 32'h0);

    for (int i = 0; i < 13; i++) begin
      axi_write(rv[i].waddr, rv[i].wdata, rv[i].wstrb, resp, dummy);
      check($sformatf("reg%0d_bresp", i), resp, rv[i].bresp);
      axi_read(rv[i].raddr, 0, data, resp, dummy);
      check($sformatf("reg%0d_rdata", i), data, rv[i].rdata);
      check($sformatf("reg%0d_rresp", i), resp, rv[i].rresp);
    end

    for (int i = 0; i < 9; i++) begin
      axi_write(8'h10, runs[i].o0, 4'hF, resp, dummy);
      axi_write(8'h14, runs[i].o1, 4'hF, resp, dummy);
      axi_write(8'h18, runs[i].o2, 4'hF, resp, dummy);
      axi_write(8'h1C, runs[i].o3, 4'hF, resp, dummy);
      axi_write(8'h00, {29'd0, runs[i].ctrl}, 4'h1, resp, dummy);
      check($sformatf("run%0d_start_bresp", i), resp, OKAY);
      repeat (N + 4) @(posedge clk);
      #1;
      axi_read(8'h08, 0, data, resp, dummy);
      check($sformatf("run%0d_result", i), data, runs[i].result);
      axi_read(8'h04, 0, data, resp, dummy);
      check($sformatf("run%0d_status", i), data, {29'd0, runs[i].status});
      axi_read(8'h00, 0, data, resp, dummy);
      check($sformatf("run%0d_ctrl", i), data, {29'd0, runs[i].ctrl & 3'b110});
    end

    // START at edge T: BUSY for edges T+1..T+N, DONE from T+N+1.
    axi_write(8'h10, 32'd1, 4'hF, resp, dummy);
    axi_write(8'h14, 32'd2, 4'hF, resp, dummy);
    axi_write(8'h18, 32'd3, 4'hF, resp, dummy);
    axi_write(8'h1C, 32'd4, 4'hF, resp, dummy);
    for (int d = 0; d < 4; d++) begin
      axi_write(8'h00, 32'h1, 4'h1, resp, t_acc);
      axi_read(8'h04, d, data, resp, e_acc);
      check($sformatf("timing_d%0d_status", d), data,
            (e_acc <= t_acc + N) ? 32'h1 : 32'h2);
      repeat (N + 4) @(posedge clk);
      #1;
      axi_read(8'h08, 0, data, resp, dummy);
      check($sformatf("timing_d%0d_result", d), data, 32'd10);
    end

    // Operand write while busy is rejected.
    axi_write(8'h00, 32'h1, 4'h1, resp, dummy);
    axi_write(8'h10, 32'h99, 4'hF, resp, dummy);
    check("busy_write_bresp", resp, SLVERR);
    repeat (N + 4) @(posedge clk);
    #1;
    axi_read(8'h10, 0, data, resp, dummy);
    check("busy_write_op0", data, 32'd1);
    axi_read(8'h08, 0, data, resp, dummy);
    check("busy_write_result", data, 32'd10);

    // Read backpressure: held response, no second acceptance.
    araddr = 8'h08; arvalid = 1'b1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    if (!ok) timed_out("bp_rvalid");
    held = rdata;
    check("bp_rdata_first", held, 32'd10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_read_hold%0d", k), {rvalid, arready, rdata, rresp},
            {1'b1, 1'b0, held, OKAY});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("bp_rvalid_drop", rvalid, 1'b0);

    // Write backpressure.
    awaddr = 8'h1C; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    if (!ok) timed_out("bp_bvalid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_write_hold%0d", k), {bvalid, awready, wready, bresp},
            {1'b1, 1'b0, 1'b0, OKAY});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    axi_read(8'h1C, 0, data, resp, dummy);
    check("bp_write_value", data, 32'h5A5A_5A5A);

    // AW three cycles before W: nothing accepted until both are valid.
    awaddr = 8'h18; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("aw_only%0d_ready", k), {awready, wready, bvalid}, 3'b000);
    end
    axi_write(8'h18, 32'h1234_5678, 4'hF, resp, dummy);
    check("aw_first_bresp", resp, OKAY);
    @(negedge clk);
    check("aw_first_single", {awready, bvalid}, 2'b00);
    axi_read(8'h18, 0, data, resp, dummy);
    check("aw_first_value", data, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
